uart_tx_stim: RTL and testbench

//  8N1 UART transmitter with a small write FIFO. Stimulus source for the
//  SoC's UART RsRx inputs (mirror of the bench serial terminal that decodes RsTx).

---
 rtl/uart_tx_stim_if.sv | 16 +
 rtl/uart_tx_stim.sv | 128 ++++++++++++
 tb/tb_uart_tx_stim.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_stim_if.sv
// Host-side interface of the 8N1 UART stimulus transmitter: byte push port,
// FIFO status and the serial line itself.
interface uart_tx_stim_if #(
  parameter int FIFO_AW = 2
);
  logic [7:0]       wdata;
  logic             wr;
  logic             full;
  logic [FIFO_AW:0] level;
  logic             overflow;
  logic             busy;
  logic             tx;

  modport master (output wdata, wr, input full, level, overflow, busy, tx);
  modport slave  (input wdata, wr, output full, level, overflow, busy, tx);
endinterface

// File: rtl/uart_tx_stim.sv
// 8N1 UART transmitter fed by a small write FIFO; frames are sent LSB-first
// back-to-back with no idle gap while bytes are queued.
module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input logic            HCLK,
  input logic            HRESETn,
  uart_tx_stim_if.slave  bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, baud_end;

  // full is taken from the registered level, so a pop in the same cycle
  // never rescues a write that arrives while full.
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign push     = bus.wr && !full;
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = mem_q[rptr_q];
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: if (baud_end) begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: if (baud_end) begin
        if (bit_q == 3'd7) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: if (baud_end) begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      level_q <= level_d;
      ovf_q   <= bus.wr && full;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: the FIFO storage is not reset; only pointers and level define its contents.
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wptr_q] <= bus.wdata;
  end

  assign bus.full     = full;
  assign bus.level    = level_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_stim.sv
// Bench for uart_tx_stim: frame-level reference model checked every cycle,
// a line receiver, and directed scenarios with hand-computed expectations.
module tb_uart_tx_stim;
  localparam int C     = 16;
  localparam int C2    = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  always #5 HCLK = ~HCLK;

  uart_tx_stim_if #(.FIFO_AW(AW)) bus ();
  uart_tx_stim_if #(.FIFO_AW(AW)) bus2 ();

  uart_tx_stim #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
  uart_tx_stim #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of accepted bytes and a cycle count into the
  // current 10-bit frame; the line level follows from the frame bit index.
  logic [7:0] mq[$];
  logic       m_active = 1'b0;
  logic [7:0] m_cur = 8'h00;
  int         m_t = 0;
  logic       m_ovf = 1'b0;
  logic       m_was_full, m_pop;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_was_full = (mq.size() == DEPTH);
      m_pop      = (mq.size() > 0) && (!m_active || m_t == 10*C - 1);
      if (m_active) begin
        if (m_t == 10*C - 1) begin
          if (m_pop) begin m_cur = mq.pop_front(); m_t = 0; end
          else m_active = 1'b0;
        end else begin
          m_t++;
        end
      end else if (m_pop) begin
        m_cur = mq.pop_front();
        m_active = 1'b1;
        m_t = 0;
      end
      if (bus.wr && !m_was_full) mq.push_back(bus.wdata);
      m_ovf = bus.wr && m_was_full;
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  logic cmp_en = 1'b0;
  always @(negedge HCLK) begin
    if (cmp_en) begin
      check("tx",       32'(bus.tx),       32'(exp_tx()));
      check("busy",     32'(bus.busy),     32'(m_active));
      check("level",    32'(bus.level),    32'(mq.size()));
      check("full",     32'(bus.full),     32'(mq.size() == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  // Line receiver sampling mid-bit, and trackers for busy runs and overflow pulses.
  logic [7:0] rxq[$];
  logic [7:0] rx_sh = 8'h00;
  logic       rx_on = 1'b0;
  int         rx_cnt = 0;
  always @(negedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_on  = 1'b0;
      rx_cnt = 0;
    end else if (!rx_on) begin
      if (bus.tx == 1'b0) begin rx_on = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt > C && rx_cnt < 9*C && (rx_cnt % C) == C/2) rx_sh = {bus.tx, rx_sh[7:1]};
      if (rx_cnt == 9*C + C/2) begin
        check("rx_stop_bit", 32'(bus.tx), 32'd1);
        rxq.push_back(rx_sh);
        rx_on = 1'b0;
      end
    end
  end

  int busy_run = 0;
  int runs[$];
  int ovf_cnt = 0;
  always @(negedge HCLK) begin
    if (bus.busy) busy_run++;
    else if (busy_run > 0) begin runs.push_back(busy_run); busy_run = 0; end
    if (bus.overflow) ovf_cnt++;
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge HCLK); n++; end
    while ((bus.busy || bus.level != 0) && n < budget);
    if (n >= budget) check("idle_timeout", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge HCLK);
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (bus.tx === lvl && len < 2000) begin len++; @(negedge HCLK); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2[4];
    int         l2[4];
    int         l3[6];
    int         r0, x0, o0, len, n;
    logic [9:0] exp10;
    logic       s[20];
    logic [7:0] dec;

    bus.wr = 1'b0;  bus.wdata = 8'h00;
    bus2.wr = 1'b0; bus2.wdata = 8'h00;
    #2 HRESETn = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge HCLK);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // 1: single 'A', one-cycle latency, 160-cycle frame
    r0 = runs.size(); x0 = rxq.size();
    bus.wr = 1'b1; bus.wdata = 8'h41;
    @(posedge HCLK); #1 bus.wr = 1'b0;
    check("t1_level_after_write", 32'(bus.level), 32'd1);
    check("t1_tx_before_pop", 32'(bus.tx), 32'd1);
    @(posedge HCLK); #1;
    check("t1_tx_start", 32'(bus.tx), 32'd0);
    check("t1_busy_start", 32'(bus.busy), 32'd1);
    check("t1_level_after_pop", 32'(bus.level), 32'd0);
    wait_idle(1000);
    check("t1_busy_len", 32'(runs[r0]), 32'd160);
    check("t1_rx_count", 32'(rxq.size() - x0), 32'd1);
    check("t1_rx_byte", 32'(rxq[x0]), 32'h41);

    // 2: "Hi\nU" back-to-back
    t2 = '{8'h48, 8'h69, 8'h0A, 8'h55};
    l2 = '{1, 1, 2, 3};
    r0 = runs.size(); x0 = rxq.size();
    @(negedge HCLK);
    for (int i = 0; i < 4; i++) begin
      bus.wr = 1'b1; bus.wdata = t2[i];
      @(posedge HCLK); #1;
      check("t2_level", 32'(bus.level), 32'(l2[i]));
    end
    bus.wr = 1'b0;
    wait_idle(2000);
    check("t2_busy_len", 32'(runs[r0]), 32'd640);
    check("t2_rx_count", 32'(rxq.size() - x0), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_rx_byte", 32'(rxq[x0+i]), 32'(t2[i]));

    // 3: six pushes, sixth dropped
    l3 = '{1, 1, 2, 3, 4, 4};
    r0 = runs.size(); x0 = rxq.size(); o0 = ovf_cnt;
    @(negedge HCLK);
    for (int i = 0; i < 6; i++) begin
      bus.wr = 1'b1; bus.wdata = 8'(8'h10 + i);
      @(posedge HCLK); #1;
      check("t3_level", 32'(bus.level), 32'(l3[i]));
      if (i == 4) check("t3_full_at_4", 32'(bus.full), 32'd1);
      if (i == 5) check("t3_overflow_pulse", 32'(bus.overflow), 32'd1);
    end
    bus.wr = 1'b0;
    @(posedge HCLK); #1;
    check("t3_overflow_clear", 32'(bus.overflow), 32'd0);
    wait_idle(3000);
    check("t3_overflow_count", 32'(ovf_cnt - o0), 32'd1);
    check("t3_busy_len", 32'(runs[r0]), 32'd800);
    check("t3_rx_count", 32'(rxq.size() - x0), 32'd5);
    for (int i = 0; i < 5; i++) check("t3_rx_byte", 32'(rxq[x0+i]), 32'(8'h10 + i));

    // 4: 0x00 then 0xFF line pattern
    r0 = runs.size(); x0 = rxq.size();
    @(negedge HCLK);
    bus.wr = 1'b1; bus.wdata = 8'h00;
    @(posedge HCLK); #1 bus.wdata = 8'hFF;
    @(posedge HCLK); #1 bus.wr = 1'b0;
    @(negedge HCLK);
    n = 0;
    while (bus.tx !== 1'b0 && n < 100) begin @(negedge HCLK); n++; end
    run_len(1'b0, len); check("t4_low_9bits", 32'(len), 32'(9*C));
    run_len(1'b1, len); check("t4_stop_1bit", 32'(len), 32'(C));
    run_len(1'b0, len); check("t4_start_1bit", 32'(len), 32'(C));
    len = 0;
    while (bus.tx === 1'b1 && bus.busy && len < 2000) begin len++; @(negedge HCLK); end
    check("t4_high_9bits", 32'(len), 32'(9*C));
    wait_idle(1000);
    check("t4_busy_len", 32'(runs[r0]), 32'd320);
    check("t4_rx_byte0", 32'(rxq[x0]), 32'h00);
    check("t4_rx_byte1", 32'(rxq[x0+1]), 32'hFF);

    // 5: async reset mid-DATA of a 3-byte burst
    x0 = rxq.size();
    @(negedge HCLK);
    for (int i = 0; i < 3; i++) begin
      bus.wr = 1'b1; bus.wdata = 8'(8'h31 + i);
      @(posedge HCLK); #1;
    end
    bus.wr = 1'b0;
    repeat (4*C) @(negedge HCLK);
    check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
    check("t5_level_before_rst", 32'(bus.level), 32'd2);
    #2 HRESETn = 1'b0;
    #1;
    check("t5_rst_tx", 32'(bus.tx), 32'd1);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_level", 32'(bus.level), 32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    n = 0;
    repeat (300) begin @(negedge HCLK); if (bus.busy || !bus.tx) n++; end
    check("t5_no_frames_after_rst", 32'(n), 32'd0);
    check("t5_rx_nothing", 32'(rxq.size() - x0), 32'd0);

    // 6: CLKS_PER_BIT=2, byte 0xA5
    exp10 = {1'b1, 8'hA5, 1'b0};
    @(negedge HCLK);
    bus2.wr = 1'b1; bus2.wdata = 8'hA5;
    @(posedge HCLK); #1 bus2.wr = 1'b0;
    check("t6_level", 32'(bus2.level), 32'd1);
    @(posedge HCLK); #1;
    check("t6_tx_start", 32'(bus2.tx), 32'd0);
    check("t6_busy_start", 32'(bus2.busy), 32'd1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK);
      s[k] = bus2.tx;
      if (bus2.busy) n++;
      check("t6_line_bit", 32'(s[k]), 32'(exp10[k/2]));
    end
    check("t6_busy_len", 32'(n), 32'd20);
    @(negedge HCLK);
    check("t6_busy_end", 32'(bus2.busy), 32'd0);
    check("t6_tx_idle", 32'(bus2.tx), 32'd1);
    dec = 8'h00;
    for (int j = 0; j < 8; j++) dec[j] = s[2*(j+1)];
    check("t6_decoded", 32'(dec), 32'hA5);

    repeat (4) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
